// File: rtl/timer_bus_if.sv
// timer_bus_if: CPU data-bus view of the timer peripheral (address, strobes, read return).
interface timer_bus_if;
  logic [15:0] a;
  logic [7:0] wdata;
  logic rd;
  logic wr;
  logic [7:0] rdata;
  logic rvalid;
  logic sel;
  modport master(output a, wdata, rd, wr, input rdata, rvalid, sel);
  modport slave(input a, wdata, rd, wr, output rdata, rvalid, sel);
endinterface

// File: rtl/timer_unit.sv
// timer_unit: memory-mapped DIV/TIMA/TMA/TAC divider-timer with overflow reload and irq pulse.
module timer_unit #(
  parameter logic [15:0] BASE_ADDR = 16'hFF04,
  parameter logic [15:0] CNT_RESET = 16'h0000
) (
  input logic clk,
  input logic rst,
  input logic tick,
  timer_bus_if.slave bus,
  output logic irq
);
  logic [15:0] cnt, cnt_n, off;
  logic [7:0] tima, tma, tma_n, rd_mux;
  logic [2:0] tac, tac_n;
  logic ovf_pend, t_q, t_n, sel_bit, w_div, w_tima, w_tma, w_tac, rd_en, inc;
  assign off = bus.a - BASE_ADDR;
  assign bus.sel = off < 16'd4;
  // Timer input is taken from next-state cnt/tac so DIV and TAC writes produce edges in the same cycle.
  always_comb begin
    w_div = bus.wr & bus.sel & (off[1:0] == 2'd0);
    w_tima = bus.wr & bus.sel & (off[1:0] == 2'd1);
    w_tma = bus.wr & bus.sel & (off[1:0] == 2'd2);
    w_tac = bus.wr & bus.sel & (off[1:0] == 2'd3);
    rd_en = bus.rd & bus.sel;
    cnt_n = w_div ? 16'h0000 : cnt + {15'd0, tick};
    tac_n = w_tac ? bus.wdata[2:0] : tac;
    tma_n = w_tma ? bus.wdata : tma;
    sel_bit = tac_n[1] ? (tac_n[0] ? cnt_n[7] : cnt_n[5]) : (tac_n[0] ? cnt_n[3] : cnt_n[9]);
    t_n = tac_n[2] & sel_bit;
    inc = t_q & ~t_n & ~w_tima;
    rd_mux = off[1] ? (off[0] ? {5'b11111, tac} : tma) : (off[0] ? tima : cnt[15:8]);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= CNT_RESET;
      tima <= 8'h00;
      tma <= 8'h00;
      tac <= 3'd0;
      ovf_pend <= 1'b0;
      t_q <= 1'b0;
      irq <= 1'b0;
      bus.rdata <= 8'h00;
      bus.rvalid <= 1'b0;
    end else begin
      cnt <= cnt_n;
      tac <= tac_n;
      tma <= tma_n;
      t_q <= t_n;
      irq <= ovf_pend & ~w_tima;
      ovf_pend <= ~ovf_pend & inc & (tima == 8'hFF);
      tima <= w_tima ? bus.wdata : ovf_pend ? tma_n : inc ? tima + 8'd1 : tima;
      bus.rvalid <= rd_en;
      if (rd_en) bus.rdata <= rd_mux;
    end
  end
endmodule

// File: tb/tb_timer_unit.sv
// tb_timer_unit: vector table, directed corner sequences and a randomized run against a behavioural model.
module tb_timer_unit;
  logic clk = 0, rst = 0, tick = 0;
  logic irq;
  int total = 0, passed = 0;
  timer_bus_if bus();
  timer_unit dut(.clk(clk), .rst(rst), .tick(tick), .bus(bus), .irq(irq));
  always #5 clk = ~clk;

  typedef struct {
    logic r, t;
    logic [15:0] a;
    logic [7:0] d;
    logic rdx, wrx, e_sel, e_rv;
    logic [7:0] e_rdata;
    logic e_irq;
  } vec_t;
  vec_t vt[12];

  int m_cnt, m_tima, m_tma, m_tac, m_pend, m_t, m_irq, m_rdata, m_rv;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic t, input logic [15:0] addr, input logic [7:0] d,
                       input logic rdx, input logic wrx);
    rst = r; tick = t; bus.a = addr; bus.wdata = d; bus.rd = rdx; bus.wr = wrx;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic t);
    drive(1, t, 16'h0000, 8'h00, 0, 0);
    repeat (n) cyc();
  endtask

  task automatic wreg(input logic [15:0] addr, input logic [7:0] d);
    drive(1, 0, addr, d, 0, 1);
    cyc();
  endtask

  task automatic do_reset();
    drive(0, 0, 16'h0000, 8'h00, 0, 0);
    cyc();
  endtask

  // Behavioural model: one call per clock edge, from the register-level rules of the peripheral.
  task automatic m_step(input logic r, input logic t, input logic [15:0] addr, input logic [7:0] d,
                        input logic rdx, input logic wrx);
    int off, nc, ntac, ntma, tin;
    int idx[4];
    bit hit;
    idx = '{9, 3, 5, 7};
    if (!r) begin
      m_cnt = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_pend = 0; m_t = 0;
      m_irq = 0; m_rdata = 0; m_rv = 0;
      return;
    end
    off = int'(addr) - 32'hFF04;
    hit = off >= 0 && off < 4;
    m_irq = 0;
    m_rv = (rdx && hit) ? 1 : 0;
    if (m_rv == 1)
      m_rdata = off == 0 ? m_cnt / 256 : off == 1 ? m_tima : off == 2 ? m_tma : 248 + m_tac;
    nc = (wrx && hit && off == 0) ? 0 : (m_cnt + int'(t)) % 65536;
    ntac = (wrx && hit && off == 3) ? int'(d) % 8 : m_tac;
    ntma = (wrx && hit && off == 2) ? int'(d) : m_tma;
    tin = ntac >= 4 ? (nc >> idx[ntac % 4]) & 1 : 0;
    if (wrx && hit && off == 1) begin
      m_tima = int'(d); m_pend = 0;
    end else if (m_pend == 1) begin
      m_tima = ntma; m_pend = 0; m_irq = 1;
    end else if (m_t == 1 && tin == 0) begin
      m_tima = m_tima + 1;
      if (m_tima == 256) begin m_tima = 0; m_pend = 1; end
    end
    m_t = tin; m_cnt = nc; m_tac = ntac; m_tma = ntma;
  endtask

  initial begin
    vt[0] = '{0, 1, 16'h0000, 8'h00, 0, 0, 0, 0, 8'h00, 0};
    vt[1] = '{1, 0, 16'hFF07, 8'hFF, 0, 1, 1, 0, 8'h00, 0};
    vt[2] = '{1, 0, 16'hFF07, 8'h00, 1, 0, 1, 1, 8'hFF, 0};
    vt[3] = '{1, 0, 16'hFF03, 8'h00, 1, 0, 0, 0, 8'hFF, 0};
    vt[4] = '{1, 0, 16'hFF08, 8'h00, 1, 0, 0, 0, 8'hFF, 0};
    vt[5] = '{1, 0, 16'hFF06, 8'h5A, 1, 1, 1, 1, 8'h00, 0};
    vt[6] = '{1, 0, 16'hFF06, 8'h00, 1, 0, 1, 1, 8'h5A, 0};
    vt[7] = '{1, 0, 16'hFF07, 8'hF9, 0, 1, 1, 0, 8'h5A, 0};
    vt[8] = '{1, 0, 16'hFF07, 8'h00, 1, 0, 1, 1, 8'hF9, 0};
    vt[9] = '{1, 0, 16'hFF04, 8'h00, 1, 0, 1, 1, 8'h00, 0};
    vt[10] = '{0, 0, 16'hFF06, 8'h00, 1, 0, 1, 0, 8'h00, 0};
    vt[11] = '{1, 0, 16'hFF06, 8'h00, 1, 0, 1, 1, 8'h00, 0};
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].r, vt[i].t, vt[i].a, vt[i].d, vt[i].rdx, vt[i].wrx);
      #1 chk($sformatf("vec%0d sel", i), bus.sel, vt[i].e_sel);
      cyc();
      chk($sformatf("vec%0d rvalid", i), bus.rvalid, vt[i].e_rv);
      chk($sformatf("vec%0d rdata", i), bus.rdata, vt[i].e_rdata);
      chk($sformatf("vec%0d irq", i), irq, vt[i].e_irq);
    end

    // Counter and DIV, including wrap
    do_reset();
    idle(256, 1);
    chk("div pre rvalid", bus.rvalid, 0);
    drive(1, 1, 16'hFF04, 8'h00, 1, 0);
    cyc();
    chk("div256 rvalid", bus.rvalid, 1);
    chk("div256 rdata", bus.rdata, 8'h01);
    idle(65279, 1);
    drive(1, 1, 16'hFF04, 8'h00, 1, 0);
    cyc();
    chk("div wrap rdata", bus.rdata, 8'h00);

    // TIMA counting on cnt[3]
    do_reset();
    wreg(16'hFF07, 8'h05);
    wreg(16'hFF05, 8'h00);
    idle(160, 1);
    chk("tima after 160", dut.tima, 8'h0A);
    drive(1, 0, 16'hFF07, 8'h00, 1, 0);
    cyc();
    chk("tac read", bus.rdata, 8'hFD);
    drive(1, 0, 16'hFF05, 8'h00, 1, 0);
    cyc();
    chk("tima read", bus.rdata, 8'h0A);

    // Overflow and reload
    do_reset();
    wreg(16'hFF06, 8'hF0); wreg(16'hFF05, 8'hFF); wreg(16'hFF07, 8'h05);
    idle(16, 1);
    chk("ovf tima zero", dut.tima, 8'h00);
    chk("ovf irq low", irq, 0);
    idle(1, 0);
    chk("reload tima", dut.tima, 8'hF0);
    chk("reload irq", irq, 1);
    idle(1, 0);
    chk("irq one cycle", irq, 0);

    // TIMA write in the load cycle cancels reload and irq
    do_reset();
    wreg(16'hFF06, 8'hF0); wreg(16'hFF05, 8'hFF); wreg(16'hFF07, 8'h05);
    idle(16, 1);
    wreg(16'hFF05, 8'h33);
    chk("write wins tima", dut.tima, 8'h33);
    chk("write wins irq", irq, 0);
    idle(1, 0);
    chk("write wins irq later", irq, 0);

    // TMA write in the load cycle is the value reloaded
    do_reset();
    wreg(16'hFF06, 8'hF0); wreg(16'hFF05, 8'hFF); wreg(16'hFF07, 8'h05);
    idle(16, 1);
    wreg(16'hFF06, 8'h77);
    chk("tma late tima", dut.tima, 8'h77);
    chk("tma late irq", irq, 1);

    // DIV write glitch
    do_reset();
    wreg(16'hFF07, 8'h05);
    idle(8, 1);
    wreg(16'hFF04, 8'hAB);
    chk("glitch cnt", dut.cnt, 16'h0000);
    chk("glitch tima", dut.tima, 8'h01);
    wreg(16'hFF07, 8'h01);
    idle(8, 1);
    wreg(16'hFF04, 8'h00);
    chk("no glitch disabled", dut.tima, 8'h01);

    // Tick gating, then reset while overflow pending
    idle(5, 1);
    idle(100, 0);
    chk("gated cnt", dut.cnt, 16'h0005);
    chk("gated tima", dut.tima, 8'h01);
    wreg(16'hFF06, 8'hF0); wreg(16'hFF05, 8'hFF); wreg(16'hFF07, 8'h05);
    idle(11, 1);
    chk("pend set", dut.ovf_pend, 1);
    do_reset();
    chk("rst tima", dut.tima, 8'h00);
    chk("rst tma", dut.tma, 8'h00);
    chk("rst tac", dut.tac, 3'd0);
    chk("rst cnt", dut.cnt, 16'h0000);
    chk("rst irq", irq, 0);
    chk("rst rvalid", bus.rvalid, 0);
    idle(1, 0);
    chk("rst no irq", irq, 0);

    // Randomized run against the model
    drive(0, 0, 16'h0000, 8'h00, 0, 0);
    m_step(0, 0, 16'h0000, 8'h00, 0, 0);
    cyc();
    for (int i = 0; i < 3000; i++) begin
      logic r, t, rdx, wrx;
      logic [15:0] addr;
      logic [7:0] d;
      r = $urandom_range(0, 199) != 0;
      t = $urandom_range(0, 3) != 0;
      addr = $urandom_range(0, 15) < 13 ? 16'hFF00 + 16'($urandom_range(0, 15)) : 16'($urandom);
      d = $urandom_range(0, 1) == 1 ? 8'hF8 + 8'($urandom_range(0, 7)) : 8'($urandom);
      rdx = $urandom_range(0, 2) == 0;
      wrx = $urandom_range(0, 5) == 0;
      drive(r, t, addr, d, rdx, wrx);
      #1 chk("rnd sel", bus.sel, (addr >= 16'hFF04 && addr <= 16'hFF07) ? 1 : 0);
      m_step(r, t, addr, d, rdx, wrx);
      cyc();
      chk("rnd rvalid", bus.rvalid, m_rv[0]);
      chk("rnd rdata", bus.rdata, m_rdata[7:0]);
      chk("rnd irq", irq, m_irq[0]);
      chk("rnd tima", dut.tima, m_tima[7:0]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/timer_unit.md
Name: timer_unit

Overview:
- Memory-mapped divider/timer peripheral on the CPU data bus. Consumes the CPU's `a`, `dout`, `rd` and `wr` outputs.
- Returns read data for the CPU's `din` mux.
- Raises the timer interrupt request that the top level ORs into `int_flags_in` bit 2.
- Register set: DIV, TIMA, TMA, TAC at four consecutive addresses from BASE_ADDR.

Parameters:
- BASE_ADDR, 16'hFF04: address of DIV. TIMA is at +1, TMA at +2, TAC at +3.
- CNT_RESET, 16'h0000: reset value of the internal 16-bit divider counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset. rst=0 at a rising edge resets all state.
- tick  input  1  machine-cycle enable from the CPU. Counter advances only on cycles with tick=1.
- a  input  16  CPU address bus.
- wdata  input  8  CPU write data (CPU `dout`).
- rd  input  1  CPU read strobe.
- wr  input  1  CPU write strobe.
- rdata  output  8  registered read data.
- rvalid  output  1  high for one cycle when rdata holds a read of this block.
- sel  output  1  combinational. High when a is in BASE_ADDR..BASE_ADDR+3; used by the top-level din mux.
- irq  output  1  one-cycle timer interrupt pulse.

Behaviour:

Reset:
- cnt=CNT_RESET; TIMA=0, TMA=0, TAC=0.
- rdata=0, rvalid=0, irq=0.
- ovf_pend=0; edge-detect register=0.

Counter:
- 16-bit cnt increments by 1 on each clk with tick=1; wraps FFFF->0000.
- DIV reads as cnt[15:8].

Timer input:
- Selected bit by TAC[1:0]: 00->cnt[9], 01->cnt[3], 10->cnt[5], 11->cnt[7].
- t_in = TAC[2] & selected bit.
- A registered copy detects a 1->0 falling edge of t_in. Each falling edge increments TIMA once.
- The edge may be caused by counting, a DIV write, or a TAC write (enable cleared, or select changed). All three increment TIMA.

Overflow:
- TIMA=FF plus increment -> TIMA=00 and ovf_pend=1.
- On the next clk: TIMA<=TMA, irq=1 for exactly that one cycle, ovf_pend<=0.
- TMA is sampled in that load cycle, so a TMA write in the overflow cycle is used.

Writes:
- A write occurs on every clk with wr=1 and sel=1; offset is a-BASE_ADDR.
- DIV: any write clears cnt to 0000; wdata is ignored.
- TIMA: loads wdata. If ovf_pend=1, the write also cancels the reload and the irq (write wins). A falling edge in the same cycle as a TIMA write is discarded.
- TMA: loads wdata.
- TAC: loads wdata[2:0].
- Writes outside the window are ignored.

Reads:
- rd=1 and sel=1 in cycle N -> rvalid=1 and rdata valid in cycle N+1. This matches the one-cycle latency of the synchronous boot ROM.
- Read values: DIV=cnt[15:8]; TIMA; TMA; TAC={5'b11111,TAC[2:0]}.
- A read in the same cycle as a write returns the pre-write value.
- Otherwise rvalid=0 and rdata holds its last value.
- rd and wr together: both actions occur.

Other rules:
- tick=0: no counting. Writes, reads and the ovf_pend->reload step still occur.
- Reset asserted mid-operation (including with ovf_pend=1) -> all state returns to reset values next edge. No irq is issued.

Test Plan:
1. Counter and DIV: release reset with tick=1 continuous. After 256 ticks, reading FF04 returns 01 with rvalid one cycle after rd. After 65536 ticks DIV wraps to 00.
2. TIMA counting: write TAC=05, TIMA=00. After 160 ticks from cnt=0, TIMA=0A. Reading FF07 returns FD.
3. Overflow and reload: TMA=F0, TIMA=FF, TAC=05, 16 ticks -> TIMA=00 for one cycle. Next cycle TIMA=F0 and irq high exactly one cycle.
4. Write-wins: same setup as 3; write TIMA=33 in the cycle after overflow -> TIMA=33, irq never asserts. Separately, a TMA=77 write in the overflow cycle -> TIMA reloads 77.
5. DIV-write glitch: TAC=05, let cnt[3]=1 (cnt=0008), write FF04 -> cnt=0000 and TIMA increments by 1. TAC=01 with cnt=0008 and a DIV write -> TIMA unchanged.
6. Reset and tick gating: hold tick=0 for 100 cycles -> DIV and TIMA unchanged. Assert rst=0 for one edge with ovf_pend=1 -> all registers 0, irq=0, rvalid=0.
